sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo.sv | 63 ++++++
 tb/tb_sync_fifo.sv | 98 +++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered read data and status flags; SYNC_FIFO_LEVEL_EN adds the level port
module sync_fifo #(
    parameter int fifo_addr_size   = 5,
    parameter int fifo_data_size   = 16,
    parameter int almost_full_thr  = 2,
    parameter int almost_empty_thr = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      w_en,
    input  logic [fifo_data_size-1:0] data_in,
    input  logic                      r_en,
    output logic [fifo_data_size-1:0] data_out,
    output logic                      r_valid,
    output logic                      full,
    output logic                      empty,
    output logic                      almost_full,
    output logic                      almost_empty,
    output logic                      overflow,
    output logic                      underflow
`ifdef SYNC_FIFO_LEVEL_EN
    ,output logic [fifo_addr_size:0]  level
`endif
);
    localparam int depth = 1 << fifo_addr_size;
    localparam int af_lvl = depth - almost_full_thr;
    localparam int ae_lvl = almost_empty_thr;
    localparam logic [fifo_addr_size:0] ptr_one = (fifo_addr_size+1)'(1);
    logic [fifo_data_size-1:0] mem [depth];
    logic [fifo_addr_size:0] wr_ptr, rd_ptr, count;
    logic wr_ok, rd_ok;
    assign count = wr_ptr - rd_ptr;
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[fifo_addr_size-1:0] == rd_ptr[fifo_addr_size-1:0]) && (wr_ptr[fifo_addr_size] != rd_ptr[fifo_addr_size]);
    assign almost_full = count >= af_lvl[fifo_addr_size:0];
    assign almost_empty = count <= ae_lvl[fifo_addr_size:0];
    assign wr_ok = w_en && !full && !rst;
    assign rd_ok = r_en && !empty;
`ifdef SYNC_FIFO_LEVEL_EN
    assign level = count;
`endif
    always_ff @(posedge clk)
        if (wr_ok) mem[wr_ptr[fifo_addr_size-1:0]] <= data_in;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            r_valid   <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ptr_one;
            if (rd_ok) begin
                rd_ptr   <= rd_ptr + ptr_one;
                data_out <= mem[rd_ptr[fifo_addr_size-1:0]];
            end
            r_valid   <= rd_ok;
            overflow  <= w_en && full;
            underflow <= r_en && empty;
        end
    end
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo; level checks compiled in with SYNC_FIFO_LEVEL_EN
module tb_sync_fifo;
    localparam int DEPTH = 32;
    logic clk = 0, rst = 0, w_en = 0, r_en = 0;
    logic [15:0] data_in = 0, data_out;
    logic r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
`ifdef SYNC_FIFO_LEVEL_EN
    logic [5:0] level;
`endif
    int checks = 0, fails = 0;
    logic [15:0] q[$];
    logic [15:0] last_dout = 0;

    sync_fifo dut (
        .clk(clk), .rst(rst), .w_en(w_en), .data_in(data_in), .r_en(r_en),
        .data_out(data_out), .r_valid(r_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .overflow(overflow), .underflow(underflow)
`ifdef SYNC_FIFO_LEVEL_EN
        , .level(level)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_flags();
        int n = q.size();
        check("empty", 32'(empty), 32'(n == 0));
        check("full", 32'(full), 32'(n == DEPTH));
        check("almost_full", 32'(almost_full), 32'(n >= DEPTH - 2));
        check("almost_empty", 32'(almost_empty), 32'(n <= 2));
`ifdef SYNC_FIFO_LEVEL_EN
        check("level", 32'(level), 32'(n));
`endif
    endtask

    task automatic step(input logic w, input logic r, input logic [15:0] d);
        int n = q.size();
        logic wa = w && n < DEPTH;
        logic ra = r && n > 0;
        w_en = w; r_en = r; data_in = d;
        @(posedge clk); #1;
        w_en = 0; r_en = 0;
        check("r_valid", 32'(r_valid), 32'(ra));
        if (ra) last_dout = q.pop_front();
        check("data_out", 32'(data_out), 32'(last_dout));
        if (wa) q.push_back(d);
        check("overflow", 32'(overflow), 32'(w && n == DEPTH));
        check("underflow", 32'(underflow), 32'(r && n == 0));
        check_flags();
    endtask

    task automatic do_reset();
        rst = 1; w_en = 1; r_en = 1; data_in = 16'hdead;
        @(posedge clk); #1;
        rst = 0; w_en = 0; r_en = 0;
        q.delete();
        last_dout = 0;
        check("rst_data_out", 32'(data_out), 0);
        check("rst_r_valid", 32'(r_valid), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_underflow", 32'(underflow), 0);
        check_flags();
    endtask

    initial begin
        #2;
        do_reset();
        for (int i = 1; i <= 3; i++) step(1, 0, 16'(i));
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        for (int i = 0; i < 32; i++) step(1, 0, 16'(16'h1000 + i));
        step(1, 0, 16'hbeef);
        step(0, 0, 0);
        step(1, 1, 16'hcafe);
        while (q.size() > 16) step(0, 1, 0);
        for (int i = 0; i < 40; i++) step(1, 1, 16'($urandom));
        while (q.size() > 10) step(0, 1, 0);
        do_reset();
        step(0, 1, 0);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, 16'($urandom));
        while (q.size() < DEPTH) step(1, 0, 16'($urandom));
        while (q.size() > 0) step(0, 1, 0);
        step(0, 1, 0);
        for (int i = 0; i < 400; i++) step($urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0, 16'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
